// File: rtl/invaders_pkg.sv
// Shared types for the invader playfield logic: position words, scanner states, hit points.
package invaders_pkg;

    localparam int POS_W = 12;
    localparam int SUM_W = POS_W + 1;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [SUM_W-1:0] sum_t;
    typedef logic [1:0]       hp_t;

    typedef enum logic {
        CS_IDLE,
        CS_SCAN
    } cs_state_e;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test with inclusive edges.
// Box A is the probe (bullet), box B the target; all sums are one bit wider than a position.
module box_overlap
    import invaders_pkg::*;
#(
    parameter int A_W = 16,
    parameter int A_H = 32,
    parameter int B_W = 64,
    parameter int B_H = 32
) (
    input  sum_t a_x_i,
    input  sum_t a_y_i,
    input  sum_t b_x_i,
    input  sum_t b_y_i,
    output logic hit_o
);

    sum_t a_right, a_bottom, b_right, b_bottom;

    assign a_right  = a_x_i + sum_t'(A_W);
    assign a_bottom = a_y_i + sum_t'(A_H);
    assign b_right  = b_x_i + sum_t'(B_W);
    assign b_bottom = b_y_i + sum_t'(B_H);

    assign hit_o = (a_x_i <= b_right) && (a_right >= b_x_i) &&
                   (a_y_i <= b_bottom) && (a_bottom >= b_y_i);

endmodule

// File: rtl/collision_scanner.sv
// Per-frame bullet/invader collision scanner: one grid cell per clock through a single comparator.
// Optional per-invader hit points are enabled with the INVADER_HP_EN macro.
//
// state   | meaning
// CS_IDLE | waiting for start; the position snapshot loads on the accepted start
// CS_SCAN | evaluating one (bullet, row, column) cell per clock from the snapshot
module collision_scanner
    import invaders_pkg::*;
#(
    parameter int NUM_COLS    = 10,
    parameter int NUM_ROWS    = 3,
    parameter int NUM_BULLETS = 2,
    parameter int ROW_OFFSET  = 100,
    parameter int INVADER_W   = 64,
    parameter int INVADER_H   = 32,
    parameter int BULLET_W    = 16,
    parameter int BULLET_H    = 32
`ifdef INVADER_HP_EN
    ,
    parameter int HP_INIT     = 3
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 wave_reset,
    input  logic [NUM_BULLETS-1:0]               bullet_active,
    input  pos_t [NUM_BULLETS-1:0]               bullet_x,
    input  pos_t [NUM_BULLETS-1:0]               bullet_y,
    input  pos_t [NUM_COLS-1:0]                  invader_x,
    input  logic [9:0]                           enemy_ypos,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]    alive,
    output logic [NUM_BULLETS-1:0]               bullet_hit,
    output logic                                 hit_valid,
    output logic [$clog2(NUM_ROWS)-1:0]          hit_row,
    output logic [$clog2(NUM_COLS)-1:0]          hit_col,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 all_cleared
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int BW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    cs_state_e                          state_q, state_d;
    logic [BW-1:0]                      b_q, b_d;
    logic [RW-1:0]                      r_q, r_d;
    logic [CW-1:0]                      c_q, c_d;

    logic [NUM_BULLETS-1:0]             snap_act_q;
    pos_t [NUM_BULLETS-1:0]             snap_bx_q, snap_by_q;
    pos_t [NUM_COLS-1:0]                snap_ix_q;
    logic [9:0]                         snap_ey_q;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0]  alive_q, alive_d;
    logic [NUM_BULLETS-1:0]             bullet_hit_q, bullet_hit_d;
    logic                               hit_valid_q, hit_valid_d;
    logic [RW-1:0]                      hit_row_q, hit_row_d;
    logic [CW-1:0]                      hit_col_q, hit_col_d;
    logic                               done_q, done_d;
    logic                               all_cleared_q;

`ifdef INVADER_HP_EN
    hp_t [NUM_ROWS-1:0][NUM_COLS-1:0]   hp_q, hp_d;
`endif

    logic scan_go;
    logic cell_ovl, cell_hit, kill, adv_bullet;
    sum_t cell_bx, cell_by, cell_ix, cell_ey;

    assign scan_go = (state_q == CS_IDLE) && start && !wave_reset;

    assign cell_bx = sum_t'(snap_bx_q[b_q]);
    assign cell_by = sum_t'(snap_by_q[b_q]);
    assign cell_ix = sum_t'(snap_ix_q[c_q]);
    assign cell_ey = sum_t'(snap_ey_q) + sum_t'(r_q * ROW_OFFSET);

    box_overlap #(
        .A_W (BULLET_W),
        .A_H (BULLET_H),
        .B_W (INVADER_W),
        .B_H (INVADER_H)
    ) u_box_overlap (
        .a_x_i (cell_bx),
        .a_y_i (cell_by),
        .b_x_i (cell_ix),
        .b_y_i (cell_ey),
        .hit_o (cell_ovl)
    );

    assign cell_hit = alive_q[r_q][c_q] & cell_ovl;

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        r_d          = r_q;
        c_d          = c_q;
        alive_d      = alive_q;
        bullet_hit_d = '0;
        hit_valid_d  = 1'b0;
        hit_row_d    = hit_row_q;
        hit_col_d    = hit_col_q;
        done_d       = 1'b0;
        kill         = 1'b0;
        adv_bullet   = 1'b0;
`ifdef INVADER_HP_EN
        hp_d         = hp_q;
`endif

        case (state_q)
            CS_IDLE: begin
                if (start) begin
                    state_d = CS_SCAN;
                    b_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            CS_SCAN: begin
                if (!snap_act_q[b_q]) begin
                    adv_bullet = 1'b1;
                end else if (cell_hit) begin
                    bullet_hit_d[b_q] = 1'b1;
`ifdef INVADER_HP_EN
                    hp_d[r_q][c_q] = hp_q[r_q][c_q] - 2'd1;
                    kill           = (hp_q[r_q][c_q] == 2'd1);
`else
                    kill = 1'b1;
`endif
                    if (kill) begin
                        alive_d[r_q][c_q] = 1'b0;
                        hit_valid_d       = 1'b1;
                        hit_row_d         = r_q;
                        hit_col_d         = c_q;
                    end
                    adv_bullet = 1'b1;
                end else if (c_q != CW'(NUM_COLS - 1)) begin
                    c_d = c_q + 1'b1;
                end else if (r_q != RW'(NUM_ROWS - 1)) begin
                    c_d = '0;
                    r_d = r_q + 1'b1;
                end else begin
                    adv_bullet = 1'b1;
                end

                if (adv_bullet) begin
                    if (b_q == BW'(NUM_BULLETS - 1)) begin
                        state_d = CS_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        b_d = b_q + 1'b1;
                        r_d = '0;
                        c_d = '0;
                    end
                end
            end
            default: state_d = CS_IDLE;
        endcase

        // Wave restart overrides everything, including pulses produced by this cycle's cell.
        if (wave_reset) begin
            state_d      = CS_IDLE;
            alive_d      = '1;
            bullet_hit_d = '0;
            hit_valid_d  = 1'b0;
            done_d       = 1'b0;
`ifdef INVADER_HP_EN
            hp_d         = {(NUM_ROWS*NUM_COLS){hp_t'(HP_INIT)}};
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= CS_IDLE;
            b_q           <= '0;
            r_q           <= '0;
            c_q           <= '0;
            alive_q       <= '1;
            bullet_hit_q  <= '0;
            hit_valid_q   <= 1'b0;
            hit_row_q     <= '0;
            hit_col_q     <= '0;
            done_q        <= 1'b0;
            all_cleared_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            b_q           <= b_d;
            r_q           <= r_d;
            c_q           <= c_d;
            alive_q       <= alive_d;
            bullet_hit_q  <= bullet_hit_d;
            hit_valid_q   <= hit_valid_d;
            hit_row_q     <= hit_row_d;
            hit_col_q     <= hit_col_d;
            done_q        <= done_d;
            all_cleared_q <= ~|alive_q;
        end
    end

`ifdef INVADER_HP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q <= {(NUM_ROWS*NUM_COLS){hp_t'(HP_INIT)}};
        end else begin
            hp_q <= hp_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_act_q <= '0;
            snap_bx_q  <= '0;
            snap_by_q  <= '0;
            snap_ix_q  <= '0;
            snap_ey_q  <= '0;
        end else if (scan_go) begin
            snap_act_q <= bullet_active;
            snap_bx_q  <= bullet_x;
            snap_by_q  <= bullet_y;
            snap_ix_q  <= invader_x;
            snap_ey_q  <= enemy_ypos;
        end
    end

    assign alive       = alive_q;
    assign bullet_hit  = bullet_hit_q;
    assign hit_valid   = hit_valid_q;
    assign hit_row     = hit_row_q;
    assign hit_col     = hit_col_q;
    assign busy        = (state_q == CS_SCAN);
    assign done        = done_q;
    assign all_cleared = all_cleared_q;

endmodule
